// File: rtl/addr_gen_strided.sv
// Strided burst address generator: emits count addresses base, base+stride, ...
// under a valid/ready handshake, in one-shot or circular mode.
module addr_gen_strided #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [LEN_WIDTH-1:0]  count,
  input  logic                  ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  valid,
  output logic                  last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  mode_q, mode_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    base_d      = base_q;
    stride_d    = stride_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    valid_d     = valid_q;
    last_d      = last_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (count != '0) begin
            base_d      = base;
            stride_d    = stride;
            count_d     = count;
            mode_d      = mode;
            remaining_d = count;
            addr_d      = base;
            state_d     = RUN;
            valid_d     = 1'b1;
            last_d      = (count == LEN_WIDTH'(1));
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        // A beat handshaken together with abort is consumed, but done stays low.
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (valid_q && ready && !last_q) begin
            addr_d      = addr_q + stride_q;
            remaining_d = remaining_q - LEN_WIDTH'(1);
          end
        end else if (valid_q && ready) begin
          if (!last_q) begin
            addr_d      = addr_q + stride_q;
            remaining_d = remaining_q - LEN_WIDTH'(1);
            last_d      = (remaining_q == LEN_WIDTH'(2));
          end else if (!mode_q) begin
            state_d     = IDLE;
            valid_d     = 1'b0;
            last_d      = 1'b0;
            remaining_d = '0;
            done_d      = 1'b1;
          end else begin
            addr_d      = base_q;
            remaining_d = count_q;
            last_d      = (count_q == LEN_WIDTH'(1));
            done_d      = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      base_q      <= '0;
      stride_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      mode_q      <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      stride_q    <= stride_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  assign addr  = addr_q;
  assign valid = valid_q;
  assign last  = last_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_addr_gen_strided.sv
// Directed self-checking bench for addr_gen_strided; observed vector is
// {valid, last, busy, done, addr}.
module tb_addr_gen_strided;

  localparam int unsigned AW = 10;
  localparam int unsigned LW = 10;

  logic          clk = 1'b0;
  logic          rst, start, abort, mode, ready;
  logic [AW-1:0] base, stride, addr;
  logic [LW-1:0] count;
  logic          valid, last, busy, done;

  int checks = 0;
  int errors = 0;

  addr_gen_strided #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .base(base), .stride(stride), .count(count), .ready(ready),
    .addr(addr), .valid(valid), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] s,
                        input logic [LW-1:0] c, input logic m);
    base = b; stride = s; count = c; mode = m; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] exp_v;
    rst = 1'b1;
    tick(); tick();
    exp_v = '0;
    checks++;
    if ({valid, last, busy, done, addr} !== exp_v) begin
      errors++;
      $display("FAIL reset: got %b expected %b", {valid, last, busy, done, addr}, exp_v);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({valid, last, busy, done, addr} !== exp_v) begin
      errors++;
      $display("FAIL reset_idle: got %b expected %b", {valid, last, busy, done, addr}, exp_v);
    end
  endtask

  task automatic test_one_shot();
    logic [13:0] exp_v;
    logic [AW-1:0] exp_tab [4];
    exp_tab[0] = 10'h010; exp_tab[1] = 10'h014; exp_tab[2] = 10'h018; exp_tab[3] = 10'h01C;
    ready = 1'b1;
    launch(10'h010, 10'd4, 10'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_v = {1'b1, (i == 3), 1'b1, 1'b0, exp_tab[i]};
      checks++;
      if ({valid, last, busy, done, addr} !== exp_v) begin
        errors++;
        $display("FAIL one_shot beat %0d: got %b expected %b", i, {valid, last, busy, done, addr}, exp_v);
      end
      tick();
    end
    exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 10'h01C};
    checks++;
    if ({valid, last, busy, done, addr} !== exp_v) begin
      errors++;
      $display("FAIL one_shot done: got %b expected %b", {valid, last, busy, done, addr}, exp_v);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL one_shot done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] exp_v;
    logic [6:0]  pat;
    int          k;
    pat = 7'b1011001;  // bit i is ready in cycle i: 1,0,0,1,1,0,1
    k = 0;
    ready = 1'b0;
    launch(10'h010, 10'd4, 10'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      ready = pat[i];
      exp_v = {1'b1, (k == 3), 1'b1, 1'b0, 10'(10'h010 + 4 * k)};
      checks++;
      if ({valid, last, busy, done, addr} !== exp_v) begin
        errors++;
        $display("FAIL backpressure cycle %0d: got %b expected %b", i, {valid, last, busy, done, addr}, exp_v);
      end
      tick();
      if (pat[i]) k++;
    end
    exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 10'h01C};
    checks++;
    if ({valid, last, busy, done, addr} !== exp_v) begin
      errors++;
      $display("FAIL backpressure done: got %b expected %b", {valid, last, busy, done, addr}, exp_v);
    end
    ready = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [13:0] exp_v;
    logic [AW-1:0] exp_tab [3];
    exp_tab[0] = 10'h3FE; exp_tab[1] = 10'h001; exp_tab[2] = 10'h004;
    ready = 1'b1;
    launch(10'h3FE, 10'd3, 10'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_v = {1'b1, (i == 2), 1'b1, 1'b0, exp_tab[i]};
      checks++;
      if ({valid, last, busy, done, addr} !== exp_v) begin
        errors++;
        $display("FAIL wrap beat %0d: got %b expected %b", i, {valid, last, busy, done, addr}, exp_v);
      end
      tick();
    end
    exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 10'h004};
    checks++;
    if ({valid, last, busy, done, addr} !== exp_v) begin
      errors++;
      $display("FAIL wrap done: got %b expected %b", {valid, last, busy, done, addr}, exp_v);
    end
    tick();
  endtask

  task automatic test_circular();
    logic [13:0] exp_v;
    ready = 1'b1;
    launch(10'h100, 10'd1, 10'd2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      exp_v = {1'b1, (i % 2 == 1), 1'b1, (i == 2 || i == 4), 10'(10'h100 + (i % 2))};
      checks++;
      if ({valid, last, busy, done, addr} !== exp_v) begin
        errors++;
        $display("FAIL circular cycle %0d: got %b expected %b", i, {valid, last, busy, done, addr}, exp_v);
      end
      if (i == 5) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    // final beat handshaken together with abort: no done
    checks++;
    if ({valid, last, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL circular abort: got %b expected 0000", {valid, last, busy, done});
    end
    tick();
  endtask

  task automatic test_abort_reset();
    logic [13:0] exp_v;
    ready = 1'b1;
    launch(10'h020, 10'd1, 10'd5, 1'b0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({valid, last, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort: got %b expected 0000", {valid, last, busy, done});
    end
    tick();
    checks++;
    if ({valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_no_done: got %b expected 000", {valid, busy, done});
    end
    launch(10'h020, 10'd1, 10'd5, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_v = '0;
    checks++;
    if ({valid, last, busy, done, addr} !== exp_v) begin
      errors++;
      $display("FAIL mid_reset: got %b expected %b", {valid, last, busy, done, addr}, exp_v);
    end
    tick();
    checks++;
    if ({valid, last, busy, done, addr} !== exp_v) begin
      errors++;
      $display("FAIL mid_reset_after: got %b expected %b", {valid, last, busy, done, addr}, exp_v);
    end
  endtask

  task automatic test_edge_starts();
    logic [13:0] exp_v;
    ready = 1'b1;
    launch(10'h055, 10'd1, 10'd0, 1'b0);
    checks++;
    if ({valid, busy, done} !== 3'b001) begin
      errors++;
      $display("FAIL zero_count: got %b expected 001", {valid, busy, done});
    end
    tick();
    checks++;
    if ({valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL zero_count_pulse: got %b expected 000", {valid, busy, done});
    end
    launch(10'h040, 10'd2, 10'd3, 1'b0);
    base = 10'h200; stride = 10'd7; count = 10'd1; mode = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_v = {1'b1, (i == 2), 1'b1, 1'b0, 10'(10'h040 + 2 * i)};
      checks++;
      if ({valid, last, busy, done, addr} !== exp_v) begin
        errors++;
        $display("FAIL start_while_busy beat %0d: got %b expected %b", i, {valid, last, busy, done, addr}, exp_v);
      end
      if (i == 2) start = 1'b0;
      tick();
    end
    exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 10'h044};
    checks++;
    if ({valid, last, busy, done, addr} !== exp_v) begin
      errors++;
      $display("FAIL start_while_busy done: got %b expected %b", {valid, last, busy, done, addr}, exp_v);
    end
    tick();
    base = 10'h123; stride = 10'd1; count = 10'd3; mode = 1'b0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 10'h044};
    checks++;
    if ({valid, last, busy, done, addr} !== exp_v) begin
      errors++;
      $display("FAIL start_abort_idle: got %b expected %b", {valid, last, busy, done, addr}, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; ready = 1'b0;
    base = '0; stride = '0; count = '0;
    test_reset();
    test_one_shot();
    test_backpressure();
    test_wrap();
    test_circular();
    test_abort_reset();
    test_edge_starts();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
